// File: rtl/thermometer_scan_decoder.sv
// Sequential thermometer-to-binary decoder: scans a captured code LSB first, one bit per clock.
// Optional macro THERM_EARLY_EXIT_EN ends the scan once no ones remain in the shift register.
module thermometer_scan_decoder #(
    parameter int K = 3,
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] code,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] count,
    output logic         bubble
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state;
    logic [W-1:0] shreg;
    logic [K-1:0] idx;
    logic         zero_seen;
    logic         last_bit;

`ifdef THERM_EARLY_EXIT_EN
    // Trailing zeros cannot change count or bubble, so stop once nothing but zeros is left.
    assign last_bit = (idx == K'(W - 1)) || (shreg[W-1:1] == '0);
`else
    assign last_bit = (idx == K'(W - 1));
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Results are cleared only on an accepted start and otherwise hold until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            idx       <= '0;
            zero_seen <= 1'b0;
            count     <= '0;
            bubble    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg     <= code;
                        idx       <= '0;
                        zero_seen <= 1'b0;
                        count     <= '0;
                        bubble    <= 1'b0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    shreg <= shreg >> 1;
                    idx   <= idx + K'(1);
                    if (shreg[0]) begin
                        if (zero_seen)
                            bubble <= 1'b1;
                        else
                            count <= count + K'(1);
                    end else begin
                        zero_seen <= 1'b1;
                    end
                    if (last_bit)
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
